// File: rtl/soc_sysid_ext_if.sv
// Bus bundle for the extended system-ID slave (Avalon-MM style, no waitrequest).
//
// Handshake: the slave accepts every request in the cycle it is presented.
// A request is a one-cycle pulse of read or write qualified by address (and
// writedata for writes). If read and write are both high, the read is
// serviced and the write is dropped. Each accepted read produces exactly one
// readdatavalid pulse on the following cycle, carrying readdata; readdata
// holds its last value whenever readdatavalid is low.
interface soc_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/soc_sysid_ext.sv
// Extended system-ID slave: build ID and timestamp words, a free-running
// uptime counter with coherent LO/HI snapshot reads, a control/status
// register (EN, CLR, sticky WRAP) and a small bank of scratch registers.
// Reads are registered: data appears with readdatavalid one cycle later.
module soc_sysid_ext #(
  parameter logic [31:0] ID_VALUE        = 32'h0,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h0,
  parameter int          UPTIME_WIDTH    = 64,
  parameter int          SCRATCH_COUNT   = 2
) (
  input  logic           clock,
  input  logic           reset,
  soc_sysid_ext_if.slave bus
);

  localparam int W = UPTIME_WIDTH;

  localparam logic [2:0] ADDR_ID     = 3'd0;
  localparam logic [2:0] ADDR_TS     = 3'd1;
  localparam logic [2:0] ADDR_UP_LO  = 3'd2;
  localparam logic [2:0] ADDR_UP_HI  = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam int         SCRATCH_BASE = 5;

  logic [W-1:0]  cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          wrap_q, wrap_d;
  logic [31:0]   hi_shadow_q;
  logic [31:0]   scratch_q [SCRATCH_COUNT];
  logic [31:0]   rdata_q;
  logic          rvalid_q;

  logic [63:0]   cnt_ext;
  logic [31:0]   rd_mux;
  logic          wr_en;
  logic          ctrl_wr;
  logic          clr;
  logic          wrap_w1c;
  logic          wrap_evt;

  // Zero-extended view of the counter so LO/HI slicing works for any width.
  assign cnt_ext = 64'(cnt_q);

  // A simultaneous read wins; the write is dropped entirely.
  assign wr_en    = bus.write & ~bus.read;
  assign ctrl_wr  = wr_en && (bus.address == ADDR_CTRL);
  assign clr      = ctrl_wr & bus.writedata[1];
  assign wrap_w1c = ctrl_wr & bus.writedata[8];
  // A clear on the would-be wrap edge lands on 0 without wrapping.
  assign wrap_evt = en_q & (&cnt_q) & ~clr;

  // Next-state for counter, enable and sticky wrap flag (wrap set beats W1C).
  always_comb begin
    cnt_d  = cnt_q;
    en_d   = en_q;
    wrap_d = wrap_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en_q) begin
      cnt_d = cnt_q + W'(1);
    end
    if (ctrl_wr) begin
      en_d = bus.writedata[0];
    end
    if (wrap_evt) begin
      wrap_d = 1'b1;
    end else if (wrap_w1c) begin
      wrap_d = 1'b0;
    end
  end

  // Read data selection; unmapped addresses return 0.
  always_comb begin
    rd_mux = 32'h0;
    case (bus.address)
      ADDR_ID:    rd_mux = ID_VALUE;
      ADDR_TS:    rd_mux = TIMESTAMP_VALUE;
      ADDR_UP_LO: rd_mux = cnt_ext[31:0];
      ADDR_UP_HI: rd_mux = hi_shadow_q;
      ADDR_CTRL:  rd_mux = {23'd0, wrap_q, 7'd0, en_q};
      default: begin
        for (int i = 0; i < SCRATCH_COUNT; i++) begin
          if (bus.address == 3'(SCRATCH_BASE + i)) begin
            rd_mux = scratch_q[i];
          end
        end
      end
    endcase
  end

  // Counter, control bits and HI shadow; a LO read latches the matching upper bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      en_q        <= 1'b1;
      wrap_q      <= 1'b0;
      hi_shadow_q <= 32'h0;
    end else begin
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      wrap_q <= wrap_d;
      if (bus.read && (bus.address == ADDR_UP_LO)) begin
        hi_shadow_q <= cnt_ext[63:32];
      end
    end
  end

  // Scratch registers, written only when no read is presented in the same cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SCRATCH_COUNT; i++) begin
      if (reset) begin
        scratch_q[i] <= 32'h0;
      end else if (wr_en && (bus.address == 3'(SCRATCH_BASE + i))) begin
        scratch_q[i] <= bus.writedata;
      end
    end
  end

  // Registered read response; readdata holds between reads, reset cancels a pending pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.read;
      if (bus.read) begin
        rdata_q <= rd_mux;
      end
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Bench for soc_sysid_ext: a 64-bit-uptime instance and an 8-bit-uptime
// instance, directed stimulus with hand-computed expectations, and a
// scoreboard monitor that pops expected read data on every readdatavalid.
module tb_soc_sysid_ext;

  localparam logic [31:0] ID64 = 32'hC0DE_0064;
  localparam logic [31:0] TS64 = 32'h2024_0611;
  localparam logic [31:0] ID8  = 32'hC0DE_0008;
  localparam logic [31:0] TS8  = 32'h2024_0612;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst64 = 1'b1;
  logic rst8  = 1'b1;
  logic rst64_seen = 1'b1;
  logic rst8_seen  = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst64_seen <= rst64;
    rst8_seen  <= rst8;
  end

  soc_sysid_ext_if b64 ();
  soc_sysid_ext_if b8 ();

  soc_sysid_ext #(
    .ID_VALUE(ID64), .TIMESTAMP_VALUE(TS64), .UPTIME_WIDTH(64), .SCRATCH_COUNT(2)
  ) dut64 (
    .clock(clk), .reset(rst64), .bus(b64)
  );

  soc_sysid_ext #(
    .ID_VALUE(ID8), .TIMESTAMP_VALUE(TS8), .UPTIME_WIDTH(8), .SCRATCH_COUNT(2)
  ) dut8 (
    .clock(clk), .reset(rst8), .bus(b8)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp64_q[$];
  logic [31:0] exp8_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic done = 1'b0;
  logic done_seen = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst64_seen) begin
      n_checks++;
      if (b64.readdatavalid !== 1'b0 || b64.readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset64: valid=%b data=%h, required valid=0 data=0",
                 b64.readdatavalid, b64.readdata);
      end
    end else if (b64.readdatavalid === 1'b1) begin
      n_checks++;
      if (exp64_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected64: valid pulse with data=%h, no read outstanding", b64.readdata);
      end else begin
        e = exp64_q.pop_front();
        if (b64.readdata !== e) begin
          n_fail++;
          $display("FAIL read64: got %h, required %h", b64.readdata, e);
        end
      end
    end
    if (rst8_seen) begin
      n_checks++;
      if (b8.readdatavalid !== 1'b0 || b8.readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset8: valid=%b data=%h, required valid=0 data=0",
                 b8.readdatavalid, b8.readdata);
      end
    end else if (b8.readdatavalid === 1'b1) begin
      n_checks++;
      if (exp8_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected8: valid pulse with data=%h, no read outstanding", b8.readdata);
      end else begin
        e = exp8_q.pop_front();
        if (b8.readdata !== e) begin
          n_fail++;
          $display("FAIL read8: got %h, required %h", b8.readdata, e);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      n_checks += 2;
      if (exp64_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain64: %0d reads never returned, required 0", exp64_q.size());
      end
      if (exp8_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain8: %0d reads never returned, required 0", exp8_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each call consumes one cycle: drive at the falling edge, sampled at the next rising edge.
  task automatic drive(input bit sel, input bit rd_i, input bit wr_i,
                       input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    if (!sel) begin
      b64.read = rd_i; b64.write = wr_i; b64.address = a; b64.writedata = d;
    end else begin
      b8.read = rd_i; b8.write = wr_i; b8.address = a; b8.writedata = d;
    end
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] e);
    drive(sel, 1'b1, 1'b0, a, 32'h0);
    if (!sel) exp64_q.push_back(e);
    else      exp8_q.push_back(e);
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    drive(sel, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) drive(sel, 1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  // k = falling-edge index after reset release; a read at k returns the counter value k.
  initial begin
    b64.read = 1'b0; b64.write = 1'b0; b64.address = 3'd0; b64.writedata = 32'h0;
    b8.read  = 1'b0; b8.write  = 1'b0; b8.address  = 3'd0; b8.writedata  = 32'h0;
    repeat (3) @(negedge clk);

    // ---- 64-bit instance ----
    @(negedge clk); rst64 = 1'b0;                    // k=0
    rd(0, 3'd0, ID64);                               // k=1
    rd(0, 3'd1, TS64);                               // k=2
    rd(0, 3'd4, 32'h1);                              // k=3
    rd(0, 3'd5, 32'h0);                              // k=4
    wr(0, 3'd5, 32'hDEAD_BEEF);                      // k=5
    wr(0, 3'd6, 32'h1234_5678);                      // k=6
    rd(0, 3'd5, 32'hDEAD_BEEF);                      // k=7
    rd(0, 3'd6, 32'h1234_5678);                      // k=8
    wr(0, 3'd0, 32'hFFFF_FFFF);                      // k=9
    rd(0, 3'd0, ID64);                               // k=10
    rd(0, 3'd7, 32'h0);                              // k=11
    rd(0, 3'd3, 32'h0);                              // k=12
    rd(0, 3'd2, 32'd13);                             // k=13
    drive(0, 1'b1, 1'b1, 3'd5, 32'hAAAA_5555);       // k=14 read wins, write dropped
    exp64_q.push_back(32'hDEAD_BEEF);
    rd(0, 3'd5, 32'hDEAD_BEEF);                      // k=15
    wr(0, 3'd4, 32'h0);                              // k=16 EN=0, last increment at this edge
    rd(0, 3'd2, 32'd17);                             // k=17
    idle(0, 10);                                     // k=18..27
    rd(0, 3'd2, 32'd17);                             // k=28 frozen
    rd(0, 3'd4, 32'h0);                              // k=29
    wr(0, 3'd4, 32'h3);                              // k=30 EN=1, CLR
    rd(0, 3'd2, 32'd0);                              // k=31
    rd(0, 3'd2, 32'd1);                              // k=32 counting again
    @(negedge clk);                                  // k=33 preload just below the LO carry
    force dut64.cnt_q = 64'h0000_0000_FFFF_FFF0;
    release dut64.cnt_q;
    b64.read = 1'b1; b64.write = 1'b0; b64.address = 3'd2;
    exp64_q.push_back(32'hFFFF_FFF0);
    idle(0, 40);                                     // k=34..73, carry happens here
    rd(0, 3'd3, 32'h0);                              // k=74 shadow from the earlier LO read
    rd(0, 3'd2, 32'h0000_001A);                      // k=75
    rd(0, 3'd3, 32'h1);                              // k=76 new shadow
    @(negedge clk);                                  // k=77 read with reset: no pulse
    b64.read = 1'b1; b64.address = 3'd0; rst64 = 1'b1;
    @(negedge clk);                                  // k=78
    b64.read = 1'b0; rst64 = 1'b0;
    rd(0, 3'd4, 32'h1);                              // k=79
    rd(0, 3'd5, 32'h0);                              // k=80
    rd(0, 3'd2, 32'd3);                              // k=81
    idle(0, 1);

    // ---- 8-bit instance ----
    @(negedge clk); rst8 = 1'b0;                     // k=0
    rd(1, 3'd2, 32'd1);                              // k=1
    idle(1, 255);                                    // k=2..256, wrap at k=255
    rd(1, 3'd4, 32'h101);                            // k=257
    rd(1, 3'd2, 32'd2);                              // k=258 restarted near 0
    wr(1, 3'd4, 32'h101);                            // k=259 clear WRAP, keep EN
    rd(1, 3'd4, 32'h1);                              // k=260
    idle(1, 250);                                    // k=261..510
    wr(1, 3'd4, 32'h101);                            // k=511 W1C on the wrap edge
    rd(1, 3'd4, 32'h101);                            // k=512 set wins
    rd(1, 3'd2, 32'd1);                              // k=513
    rd(1, 3'd3, 32'h0);                              // k=514 HI is 0 for narrow counter
    rd(1, 3'd0, ID8);                                // k=515
    idle(1, 1);

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
